mac_operand_feeder: RTL and testbench
=====================================

MAC_OPERAND_FEEDER -- requirements
Module: mac_operand_feeder

Interface
REQ-001 Parameter DEPTH, default 4, operand FIFO entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter TRI_HOLD, default 4, cycles one trinomial operand set is presented to the MAC.
REQ-003 Parameter SUMP_HOLD, default 2, cycles one sum-of-products operand set is presented to the MAC.
REQ-004 Parameter GAP, default 1, idle cycles between consecutive issues; minimum 1.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-007 in_valid  in  1  upstream operand set valid.
REQ-008 in_ready  out  1  feeder can accept an operand set.
REQ-009 in_mode  in  1  1 = trinomial (a*x+b)*x+c, 0 = sum of products.
REQ-010 in_last  in  1  final term of a sum-of-products group.
REQ-011 in_a, in_x, in_b, in_c  in  8 each  operands.
REQ-012 valid_input  out  1  to MAC valid_input.
REQ-013 last_input  out  1  to MAC last_input.
REQ-014 mode  out  1  to MAC mode.
REQ-015 num_a, num_x, num_b, num_c  out  8 each  to MAC operands.
REQ-016 mac_valid_output  in  1  MAC valid_output; used only under REQ-036.
REQ-017 busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.
REQ-018 count  out  clog2(DEPTH)+1  registered FIFO occupancy.

Function
REQ-019 A push SHALL occur on a rising edge where in_valid and in_ready are both 1; it stores {in_mode, in_last, a, x, b, c} as one entry.
REQ-020 in_ready SHALL equal (count != DEPTH) and SHALL be computed from the registered count only; a push offered when full is rejected, even if a pop occurs in the same cycle.
REQ-021 A simultaneous push and pop SHALL leave count unchanged and preserve FIFO order; read and write pointers wrap modulo DEPTH.
REQ-022 The FSM SHALL have states IDLE, ISSUE and GAP, plus WAIT under REQ-036.
REQ-023 In IDLE with count != 0, the FSM SHALL enter ISSUE on the next edge. An entry pushed into an empty FIFO therefore has valid_input high on the second edge after the push.
REQ-024 In ISSUE, mode and num_* SHALL equal the head entry and valid_input SHALL be 1, for exactly TRI_HOLD cycles if the head mode is 1, otherwise SUMP_HOLD cycles.
REQ-025 last_input SHALL be 1 throughout ISSUE when mode is 1; when mode is 0 it SHALL equal the entry's in_last.
REQ-026 On the last ISSUE cycle, the head entry SHALL be popped and the FSM SHALL enter GAP.
REQ-027 In GAP, valid_input and last_input SHALL be 0 for GAP cycles. num_* and mode SHALL hold their last issued values. After GAP the FSM SHALL go to ISSUE if count != 0, otherwise to IDLE.
REQ-028 The operands and mode of an entry SHALL NOT change while that entry is being issued; a mode change takes effect only at entry boundaries.
REQ-029 In IDLE, valid_input and last_input SHALL be 0 and num_* and mode SHALL hold their last values.
REQ-030 The hold counter SHALL be wide enough for max(TRI_HOLD, SUMP_HOLD, GAP) and SHALL never wrap within a state.
REQ-031 All MAC-facing outputs SHALL be registered, with no combinational path from in_* to them.

Reset
REQ-032 While reset is 0, the block SHALL immediately force the FSM to IDLE, pointers and count to 0, and hold counter to 0.
REQ-033 Reset values: in_ready=1, valid_input=0, last_input=0, mode=0, num_*=0, busy=0, count=0.
REQ-034 Reset asserted mid-ISSUE SHALL abort the issue and discard all FIFO entries.
REQ-035 After reset deassertion, the first push SHALL be accepted on the first edge.

Configuration
REQ-036 Macro FEEDER_WAIT_RESULT_EN.
  - Defined: GAP exits to WAIT. WAIT holds valid_input=0 until the first edge with mac_valid_output=1, then goes to ISSUE or IDLE per count.
  - Undefined: there is no WAIT state and mac_valid_output is ignored.

Verification
REQ-037 Push tri (a=5, x=3, b=2, c=1) into an empty feeder -> valid_input=1 and last_input=1 for 4 cycles, num_*=5/3/2/1, mode=1, then 1 idle cycle; the MAC produces 52.
REQ-038 Push tri (9, 8, 7, 6) then sump (a=5, x=3, in_last=1) back to back -> 4-cycle issue, 1 gap, 2-cycle issue with mode=0 and last_input=1; the MAC produces 638, then 15.
REQ-039 Push 6 sets on consecutive cycles with DEPTH=4 -> in_ready=0 when count=4, pushes 5 and 6 are held by upstream until in_ready=1, and all 6 are issued in order.
REQ-040 Assert reset=0 on the 2nd ISSUE cycle with 3 entries queued -> valid_input=0 asynchronously, count=0, in_ready=1; no further issue occurs without a new push.
REQ-041 With FEEDER_WAIT_RESULT_EN, push 2 sets and pulse mac_valid_output 7 cycles after the first issue ends -> the second issue starts on the edge after the pulse.

Source files
------------

// File: rtl/mac_operand_feeder.sv
// Operand FIFO plus issue sequencer that presents one operand set at a time to a MAC.
// Optional build macro FEEDER_WAIT_RESULT_EN adds a WAIT state gated by mac_valid_output.
module mac_operand_feeder #(
    parameter int DEPTH     = 4,
    parameter int TRI_HOLD  = 4,
    parameter int SUMP_HOLD = 2,
    parameter int GAP       = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_mode,
    input  logic                     in_last,
    input  logic [7:0]               in_a,
    input  logic [7:0]               in_x,
    input  logic [7:0]               in_b,
    input  logic [7:0]               in_c,
    output logic                     valid_input,
    output logic                     last_input,
    output logic                     mode,
    output logic [7:0]               num_a,
    output logic [7:0]               num_x,
    output logic [7:0]               num_b,
    output logic [7:0]               num_c,
    input  logic                     mac_valid_output,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int MAXH = (TRI_HOLD > SUMP_HOLD) ?
                          ((TRI_HOLD > GAP) ? TRI_HOLD : GAP) :
                          ((SUMP_HOLD > GAP) ? SUMP_HOLD : GAP);
    localparam int HW   = $clog2(MAXH + 1);

    localparam logic [CW-1:0] FULL       = CW'(DEPTH);
    localparam logic [HW-1:0] TRI_LAST   = HW'(TRI_HOLD - 1);
    localparam logic [HW-1:0] SUMP_LAST  = HW'(SUMP_HOLD - 1);
    localparam logic [HW-1:0] GAP_LAST   = HW'(GAP - 1);

    typedef struct packed {
        logic       mode;
        logic       last;
        logic [7:0] a;
        logic [7:0] x;
        logic [7:0] b;
        logic [7:0] c;
    } entry_t;

`ifdef FEEDER_WAIT_RESULT_EN
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_WAIT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;
`endif

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    state_t          r_state;
    state_t          w_state_nxt;
    logic [HW-1:0]   r_hold;
    logic [HW-1:0]   w_hold_nxt;

    logic            r_valid;
    logic            r_last;
    logic            r_mode;
    logic [7:0]      r_num_a;
    logic [7:0]      r_num_x;
    logic [7:0]      r_num_b;
    logic [7:0]      r_num_c;

    logic            w_push;
    logic            w_pop;
    logic            w_load;
    entry_t          w_head;
    entry_t          w_in_entry;
    logic [HW-1:0]   w_head_hold;

    // in_ready looks only at the registered count, so a full FIFO rejects a push even on a pop cycle.
    assign in_ready    = (r_count != FULL);
    assign w_push      = in_valid && in_ready;
    assign w_in_entry  = {in_mode, in_last, in_a, in_x, in_b, in_c};
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_hold = w_head.mode ? TRI_LAST : SUMP_LAST;

`ifndef FEEDER_WAIT_RESULT_EN
    logic w_unused_mac_valid;
    assign w_unused_mac_valid = mac_valid_output;
`endif

    // NOTE: every signal driven here gets a default first so no latch is inferred on untaken paths.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) w_load = 1'b1;
            end
            S_ISSUE: begin
                if (r_hold == '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_GAP;
                    w_hold_nxt  = GAP_LAST;
                end else begin
                    w_hold_nxt  = r_hold - 1'b1;
                end
            end
            S_GAP: begin
                if (r_hold != '0) begin
                    w_hold_nxt = r_hold - 1'b1;
                end else begin
`ifdef FEEDER_WAIT_RESULT_EN
                    w_state_nxt = S_WAIT;
`else
                    if (r_count != '0) w_load = 1'b1;
                    else               w_state_nxt = S_IDLE;
`endif
                end
            end
`ifdef FEEDER_WAIT_RESULT_EN
            S_WAIT: begin
                if (mac_valid_output) begin
                    if (r_count != '0) w_load = 1'b1;
                    else               w_state_nxt = S_IDLE;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_load) begin
            w_state_nxt = S_ISSUE;
            w_hold_nxt  = w_head_hold;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_hold   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the FIFO storage has no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_in_entry;
    end

    // MAC-facing registers are captured only at an entry boundary, so they cannot change mid-issue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_mode  <= 1'b0;
            r_num_a <= '0;
            r_num_x <= '0;
            r_num_b <= '0;
            r_num_c <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_last  <= w_head.mode | w_head.last;
            r_mode  <= w_head.mode;
            r_num_a <= w_head.a;
            r_num_x <= w_head.x;
            r_num_b <= w_head.b;
            r_num_c <= w_head.c;
        end else if (w_state_nxt != S_ISSUE) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign valid_input = r_valid;
    assign last_input  = r_last;
    assign mode        = r_mode;
    assign num_a       = r_num_a;
    assign num_x       = r_num_x;
    assign num_b       = r_num_b;
    assign num_c       = r_num_c;
    assign count       = r_count;
    assign busy        = (r_state != S_IDLE) || (r_count != '0);

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Self-checking bench for mac_operand_feeder: vector table, directed corner cases and a
// randomized run against a schedule-level reference model.
module tb_mac_operand_feeder;

    localparam int DEPTH     = 4;
    localparam int TRI_HOLD  = 4;
    localparam int SUMP_HOLD = 2;
    localparam int GAP       = 1;
    localparam int CW        = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic          in_last;
    logic [7:0]    in_a, in_x, in_b, in_c;
    logic          valid_input;
    logic          last_input;
    logic          mode;
    logic [7:0]    num_a, num_x, num_b, num_c;
    logic          mac_valid_output;
    logic          busy;
    logic [CW-1:0] count;

    mac_operand_feeder #(
        .DEPTH(DEPTH), .TRI_HOLD(TRI_HOLD), .SUMP_HOLD(SUMP_HOLD), .GAP(GAP)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_last(in_last),
        .in_a(in_a), .in_x(in_x), .in_b(in_b), .in_c(in_c),
        .valid_input(valid_input), .last_input(last_input), .mode(mode),
        .num_a(num_a), .num_x(num_x), .num_b(num_b), .num_c(num_c),
        .mac_valid_output(mac_valid_output), .busy(busy), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted set gets an issue window [start, start+hold) in edge numbers.
    typedef struct {
        bit       mode;
        bit       last;
        bit [7:0] a, x, b, c;
        int       start;
        int       hold;
    } ent_t;

    ent_t q[$];
    int   e;
    int   last_free;

    task automatic model_clear();
        q.delete();
        e         = 0;
        last_free = 0;
    endtask

    function automatic int occ();
        int n = 0;
        foreach (q[i]) if (q[i].start + q[i].hold > e) n++;
        return n;
    endfunction

    task automatic model_check();
        bit       ev = 0, el = 0, em = 0, eb = 0;
        bit [7:0] ea = 0, ex = 0, ebb = 0, ec = 0;
        int       n;
        foreach (q[i]) begin
            if (q[i].start <= e) begin
                em = q[i].mode; ea = q[i].a; ex = q[i].x; ebb = q[i].b; ec = q[i].c;
                ev = (e < q[i].start + q[i].hold);
                el = ev && (q[i].mode || q[i].last);
                if (e < q[i].start + q[i].hold + GAP) eb = 1;
            end
        end
        n  = occ();
        eb = eb || (n != 0);
        check("mac_out", {valid_input, last_input, mode, num_a, num_x, num_b, num_c},
              {ev, el, em, ea, ex, ebb, ec});
        check("fifo_state", {count, in_ready, busy}, {CW'(n), (n != DEPTH), eb});
    endtask

    // One clock: drive inputs, advance an edge, update the model, compare at the falling edge.
    task automatic step(input bit v, input bit m, input bit l,
                        input bit [7:0] a, input bit [7:0] x, input bit [7:0] b, input bit [7:0] c,
                        output bit acc);
        ent_t n;
        acc      = v && (occ() != DEPTH);
        in_valid = v; in_mode = m; in_last = l;
        in_a = a; in_x = x; in_b = b; in_c = c;
        @(posedge clk);
        e++;
        if (acc) begin
            n.mode = m; n.last = l; n.a = a; n.x = x; n.b = b; n.c = c;
            n.start   = (e + 1 > last_free) ? e + 1 : last_free;
            n.hold    = m ? TRI_HOLD : SUMP_HOLD;
            last_free = n.start + n.hold + GAP;
            q.push_back(n);
        end
        @(negedge clk);
        in_valid = 1'b0;
        model_check();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_clear();
    endtask

    typedef struct {
        bit v, m, l;
        bit [7:0] a, x, b, c;
        bit ev, el, em;
        bit [7:0] ea, ex, eb, ec;
        int ecnt;
        bit ebusy;
    } row_t;

    row_t tbl[17];

    initial begin
        bit acc;
        bit saw_full;
        int guard;

        reset = 1'b0;
        in_valid = 1'b0; in_mode = 1'b0; in_last = 1'b0;
        in_a = '0; in_x = '0; in_b = '0; in_c = '0;
        mac_valid_output = 1'b0;
        model_clear();

        repeat (2) @(negedge clk);
        check("reset_vals",
              {in_ready, valid_input, last_input, mode, num_a, num_x, num_b, num_c, busy, count},
              {1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, CW'(0)});
        reset = 1'b1;

`ifdef FEEDER_WAIT_RESULT_EN
        // Two tri sets; the second waits in WAIT until the pulse 7 cycles after the first ends.
        step(1, 1, 0, 8'd1, 8'd2, 8'd3, 8'd4, acc);
        in_valid = 1'b1; in_mode = 1'b1; in_last = 1'b0;
        in_a = 8'd5; in_x = 8'd6; in_b = 8'd7; in_c = 8'd8;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        for (int k = 3; k <= 14; k++) begin
            mac_valid_output = (k == 13);
            @(posedge clk); @(negedge clk);
            check("wait_valid", valid_input, ((k <= 5) || (k >= 13)));
        end
        mac_valid_output = 1'b0;
        check("wait_second_num", {num_a, num_x, num_b, num_c}, {8'd5, 8'd6, 8'd7, 8'd8});
`else
        // Single tri set, then tri followed back-to-back by a sum-of-products set.
        tbl[0]  = '{1,1,0, 5,3,2,1, 0,0,0, 0,0,0,0, 1,1};
        tbl[1]  = '{0,0,0, 0,0,0,0, 1,1,1, 5,3,2,1, 1,1};
        tbl[2]  = '{0,0,0, 0,0,0,0, 1,1,1, 5,3,2,1, 1,1};
        tbl[3]  = '{0,0,0, 0,0,0,0, 1,1,1, 5,3,2,1, 1,1};
        tbl[4]  = '{0,0,0, 0,0,0,0, 1,1,1, 5,3,2,1, 1,1};
        tbl[5]  = '{0,0,0, 0,0,0,0, 0,0,1, 5,3,2,1, 0,1};
        tbl[6]  = '{0,0,0, 0,0,0,0, 0,0,1, 5,3,2,1, 0,0};
        tbl[7]  = '{1,1,0, 9,8,7,6, 0,0,1, 5,3,2,1, 1,1};
        tbl[8]  = '{1,0,1, 5,3,0,0, 1,1,1, 9,8,7,6, 2,1};
        tbl[9]  = '{0,0,0, 0,0,0,0, 1,1,1, 9,8,7,6, 2,1};
        tbl[10] = '{0,0,0, 0,0,0,0, 1,1,1, 9,8,7,6, 2,1};
        tbl[11] = '{0,0,0, 0,0,0,0, 1,1,1, 9,8,7,6, 2,1};
        tbl[12] = '{0,0,0, 0,0,0,0, 0,0,1, 9,8,7,6, 1,1};
        tbl[13] = '{0,0,0, 0,0,0,0, 1,1,0, 5,3,0,0, 1,1};
        tbl[14] = '{0,0,0, 0,0,0,0, 1,1,0, 5,3,0,0, 1,1};
        tbl[15] = '{0,0,0, 0,0,0,0, 0,0,0, 5,3,0,0, 0,1};
        tbl[16] = '{0,0,0, 0,0,0,0, 0,0,0, 5,3,0,0, 0,0};

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].v, tbl[i].m, tbl[i].l, tbl[i].a, tbl[i].x, tbl[i].b, tbl[i].c, acc);
            check($sformatf("tbl_out[%0d]", i),
                  {valid_input, last_input, mode, num_a, num_x, num_b, num_c},
                  {tbl[i].ev, tbl[i].el, tbl[i].em, tbl[i].ea, tbl[i].ex, tbl[i].eb, tbl[i].ec});
            check($sformatf("tbl_cnt[%0d]", i), {count, busy}, {CW'(tbl[i].ecnt), tbl[i].ebusy});
        end

        // Six sets offered on consecutive cycles; upstream holds each until it is accepted.
        saw_full = 0;
        for (int i = 0; i < 6; i++) begin
            guard = 0;
            do begin
                step(1, (i % 2 == 0), 1, 8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i), 8'(8'h40 + i), acc);
                if (!in_ready) saw_full = 1;
                guard++;
            end while (!acc && guard < 40);
            if (!acc) check("push_timeout", 1'b0, 1'b1);
        end
        check("full_seen", saw_full, 1'b1);
        repeat (40) step(0, 0, 0, 0, 0, 0, 0, acc);
        check("drained", {count, busy}, {CW'(0), 1'b0});

        // Reset on the second issue cycle with three sets queued.
        apply_reset();
        step(1, 1, 0, 8'd1, 8'd1, 8'd1, 8'd1, acc);
        check("first_push_accepted", acc, 1'b1);
        step(1, 1, 0, 8'd2, 8'd2, 8'd2, 8'd2, acc);
        step(1, 0, 1, 8'd3, 8'd3, 8'd3, 8'd3, acc);
        #2 reset = 1'b0;
        #1;
        check("async_reset", {valid_input, last_input, count, in_ready},
              {1'b0, 1'b0, CW'(0), 1'b1});
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        repeat (12) step(0, 0, 0, 0, 0, 0, 0, acc);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, $urandom % 2, $urandom % 2,
                 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), acc);
        end
        repeat (40) step(0, 0, 0, 0, 0, 0, 0, acc);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
